// File: rtl/ping_trigger_seq_pkg.sv
// Shared types and default timing for the SRF04 ping sequencer.
package ping_trigger_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_WAIT_FALL = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK     = 2'b00,
        ERR_NORISE = 2'b01,
        ERR_LONG   = 2'b10,
        ERR_STUCK  = 2'b11
    } err_t;

    localparam int unsigned DEF_CNT_W    = 22;
    localparam int unsigned DEF_TRIG_CYC = 500;
    localparam int unsigned DEF_RISE_TMO = 25000;
    localparam int unsigned DEF_ECHO_TMO = 1900000;
    localparam int unsigned DEF_HOLDOFF  = 2500000;

endpackage

// File: rtl/ping_trigger_seq_if.sv
// Sensor-side and status signals of the ping sequencer; slave = sequencer.
interface ping_trigger_seq_if;

    logic       enable;
    logic       echoin;
    logic       trig;
    logic       echo_gated;
    logic       busy;
    logic       meas_done;
    logic       timeout;
    logic [1:0] err_code;

    modport slave (
        input  enable, echoin,
        output trig, echo_gated, busy, meas_done, timeout, err_code
    );

    modport master (
        output enable, echoin,
        input  trig, echo_gated, busy, meas_done, timeout, err_code
    );

endinterface

// File: rtl/ping_sync2.sv
// Two-flop synchroniser for the raw echo line; resets to 0.
module ping_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ping_trigger_seq.sv
// SRF04 measurement sequencer: issues trig, windows the synchronised echo,
// and enforces rise/echo/stuck timeouts plus the holdoff between pings.
module ping_trigger_seq
    import ping_trigger_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned TRIG_CYC = DEF_TRIG_CYC,
    parameter int unsigned RISE_TMO = DEF_RISE_TMO,
    parameter int unsigned ECHO_TMO = DEF_ECHO_TMO,
    parameter int unsigned HOLDOFF  = DEF_HOLDOFF
) (
    input  logic              clk,
    input  logic              rst_n,
    ping_trigger_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] L_TRIG_END = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] L_RISE_END = CNT_W'(RISE_TMO - 1);
    localparam logic [CNT_W-1:0] L_ECHO_END = CNT_W'(ECHO_TMO - 1);
    localparam logic [CNT_W-1:0] L_HOLD_END = CNT_W'(HOLDOFF - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_clr;
    logic             w_echo_s;
    logic             r_echo_d;
    logic             w_rise;
    logic             w_fall;
    logic             w_done;
    logic             w_tmo;
    err_t             w_err;
    logic             r_trig;
    logic             r_gated;
    logic             r_done;
    logic             r_tmo;
    err_t             r_err;

    ping_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.echoin),
        .o_q   (w_echo_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_echo_d <= 1'b0;
        else        r_echo_d <= w_echo_s;
    end

    assign w_rise = w_echo_s & ~r_echo_d;
    assign w_fall = ~w_echo_s & r_echo_d;

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_done    = 1'b0;
        w_tmo     = 1'b0;
        w_err     = ERR_OK;
        unique case (r_state)
            S_IDLE: begin
                // In IDLE the counter only measures consecutive stuck-high cycles
                if (bus.enable && !w_echo_s) begin
                    w_next = S_TRIG;
                end else if (bus.enable) begin
                    if (r_cnt == L_HOLD_END) begin
                        w_tmo     = 1'b1;
                        w_err     = ERR_STUCK;
                        w_cnt_clr = 1'b1;
                    end
                end else begin
                    w_cnt_clr = 1'b1;
                end
            end
            S_TRIG: begin
                if (r_cnt == L_TRIG_END) w_next = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    w_next = S_WAIT_FALL;
                end else if (r_cnt == L_RISE_END) begin
                    w_tmo  = 1'b1;
                    w_err  = ERR_NORISE;
                    w_next = S_HOLDOFF;
                end
            end
            S_WAIT_FALL: begin
                // Checking the edge first lets a fall on the last cycle win over the timeout
                if (w_fall) begin
                    w_done = 1'b1;
                    w_err  = ERR_OK;
                    w_next = S_HOLDOFF;
                end else if (r_cnt == L_ECHO_END) begin
                    w_tmo  = 1'b1;
                    w_err  = ERR_LONG;
                    w_next = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (r_cnt == L_HOLD_END) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_next != r_state) w_cnt_clr = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so trig spans exactly the TRIG state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig  <= 1'b0;
            r_gated <= 1'b0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
            r_err   <= ERR_OK;
        end else begin
            r_trig  <= (w_next == S_TRIG);
            r_gated <= (w_next == S_WAIT_FALL) && w_echo_s;
            r_done  <= w_done;
            r_tmo   <= w_tmo;
            if (w_done || w_tmo) r_err <= w_err;
        end
    end

    assign bus.trig       = r_trig;
    assign bus.echo_gated = r_gated;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.meas_done  = r_done;
    assign bus.timeout    = r_tmo;
    assign bus.err_code   = r_err;

endmodule

// File: tb/tb_ping_trigger_seq.sv
// Bench for ping_trigger_seq: directed ping table, reset/enable sequences,
// and random pings checked against a timeline model of each ping.
module tb_ping_trigger_seq;
    import ping_trigger_seq_pkg::*;

    localparam int TRIG_CYC = 5;
    localparam int RISE_TMO = 20;
    localparam int ECHO_TMO = 50;
    localparam int HOLDOFF  = 30;
    localparam int SYNC_LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ping_trigger_seq_if bus ();

    ping_trigger_seq #(
        .TRIG_CYC (TRIG_CYC),
        .RISE_TMO (RISE_TMO),
        .ECHO_TMO (ECHO_TMO),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit         has;
        int         d;
        int         w;
        int         evt_k;
        int         ndone;
        int         ntmo;
        logic [1:0] err;
        int         glen;
        int         next_k;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.trig, bus.echo_gated, bus.meas_done, bus.timeout, bus.busy, bus.err_code};
    endfunction

    // Raw echo for episode cycle k: rises d cycles after trig falls, lasts w cycles
    function automatic logic echo_at(input int k, input bit has, input int d, input int w);
        return has && (k >= TRIG_CYC + d) && (k < TRIG_CYC + d + w);
    endfunction

    task automatic step(input logic e);
        @(posedge clk);
        #1 bus.echoin = e;
        @(negedge clk);
    endtask

    // Runs one ping from just after its first trig cycle until the next trig rises
    task automatic run_measure(input bit has, input int d, input int w,
                               output int evt_k, output int ndone, output int ntmo,
                               output int glen, output logic [1:0] err, output int next_k);
        evt_k = -1; ndone = 0; ntmo = 0; glen = 0; next_k = -1; err = 2'bxx;
        for (int k = 1; k <= 400; k++) begin
            step(echo_at(k, has, d, w));
            if (bus.meas_done) begin ndone++; if (evt_k < 0) evt_k = k; end
            if (bus.timeout)   begin ntmo++;  if (evt_k < 0) evt_k = k; end
            if (bus.echo_gated) glen++;
            if (k >= TRIG_CYC && bus.trig) begin
                next_k = k;
                err    = bus.err_code;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tbl[9];
        int         evt_k, ndone, ntmo, glen, next_k;
        logic [1:0] err;
        logic [1:0] perr;

        tbl[0] = '{1,  8,  30, 46, 1, 0, ERR_OK,     30, 77};  // normal ping
        tbl[1] = '{0,  0,   0, 25, 0, 1, ERR_NORISE,  0, 56};  // no echo
        tbl[2] = '{1,  8,  80, 66, 0, 1, ERR_LONG,   50, 97};  // long echo
        tbl[3] = '{1,  8,  50, 66, 1, 0, ERR_OK,     50, 97};  // fall on last cycle
        tbl[4] = '{1,  8,  51, 66, 0, 1, ERR_LONG,   50, 97};  // one cycle too long
        tbl[5] = '{1, 17,  10, 35, 1, 0, ERR_OK,     10, 66};  // rise on last cycle
        tbl[6] = '{1, 18,  10, 25, 0, 1, ERR_NORISE,  0, 56};  // rise one cycle late
        tbl[7] = '{1,  0,   1,  9, 1, 0, ERR_OK,      1, 40};  // shortest echo
        tbl[8] = '{1,  8, 150, 66, 0, 3, ERR_STUCK,  50, 166}; // stuck high into IDLE

        bus.enable = 1'b0;
        bus.echoin = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(outs()), 32'd0);

        rst_n      = 1'b1;
        bus.enable = 1'b1;
        step(1'b0);
        check("first_trig", 32'(bus.trig), 32'd1);

        foreach (tbl[i]) begin
            run_measure(tbl[i].has, tbl[i].d, tbl[i].w, evt_k, ndone, ntmo, glen, err, next_k);
            check($sformatf("tbl%0d_evt_k", i),  32'(evt_k),  32'(tbl[i].evt_k));
            check($sformatf("tbl%0d_ndone", i),  32'(ndone),  32'(tbl[i].ndone));
            check($sformatf("tbl%0d_ntmo", i),   32'(ntmo),   32'(tbl[i].ntmo));
            check($sformatf("tbl%0d_err", i),    32'(err),    32'(tbl[i].err));
            check($sformatf("tbl%0d_glen", i),   32'(glen),   32'(tbl[i].glen));
            check($sformatf("tbl%0d_next_k", i), 32'(next_k), 32'(tbl[i].next_k));
        end

        // enable dropped inside WAIT_FALL: ping completes, holdoff runs, then parks
        begin
            int   done_k = -1;
            int   ntrig  = 0;
            logic busy75 = 1'b0;
            for (int k = 1; k <= 200; k++) begin
                step(echo_at(k, 1'b1, 8, 30));
                if (k == 20) bus.enable = 1'b0;
                if (bus.meas_done && done_k < 0) done_k = k;
                if (k >= TRIG_CYC && bus.trig) ntrig++;
                if (k == 75) busy75 = bus.busy;
            end
            check("drop_done_k",  32'(done_k),       32'd46);
            check("drop_busy_ho", 32'(busy75),       32'd1);
            check("drop_parked",  32'(bus.busy),     32'd0);
            check("drop_no_trig", 32'(ntrig),        32'd0);
            check("drop_err",     32'(bus.err_code), 32'(ERR_OK));
            @(posedge clk);
            #1 bus.enable = 1'b1;
            @(negedge clk);
            check("reen_wait", 32'(bus.trig), 32'd0);
            step(1'b0);
            check("reen_trig", 32'(bus.trig), 32'd1);
        end

        // async reset between edges in the middle of TRIG
        run_measure(1'b0, 0, 0, evt_k, ndone, ntmo, glen, err, next_k);
        check("pre_rst_err", 32'(err), 32'(ERR_NORISE));
        step(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 32'({bus.trig, bus.busy, bus.err_code}), 32'd0);
        @(negedge clk);
        check("rst_hold", 32'(outs()), 32'd0);
        #2 rst_n = 1'b1;
        step(1'b0);
        check("rst_release_trig", 32'({bus.trig, bus.busy}), 32'b11);

        // random pings against a timeline model
        perr = ERR_OK;
        for (int ep = 0; ep < 40; ep++) begin
            bit         has, isdone;
            int         d, w, r, evt, glo, ghi, nxt;
            logic [1:0] enew;
            logic [6:0] exp_v;
            has = ($urandom_range(0, 4) != 0);
            d   = $urandom_range(0, RISE_TMO - 1 - SYNC_LAT);
            w   = $urandom_range(1, ECHO_TMO + 10);
            if (!has) begin
                evt = TRIG_CYC + RISE_TMO; isdone = 1'b0; enew = ERR_NORISE;
                glo = 1; ghi = 0;
            end else begin
                r   = TRIG_CYC + d + SYNC_LAT;
                glo = r + 1;
                if (w <= ECHO_TMO) begin
                    evt = r + w + 1; isdone = 1'b1; enew = ERR_OK; ghi = r + w;
                end else begin
                    evt = r + ECHO_TMO + 1; isdone = 1'b0; enew = ERR_LONG; ghi = r + ECHO_TMO;
                end
            end
            nxt = evt + HOLDOFF + 1;
            for (int k = 1; k <= nxt; k++) begin
                step(echo_at(k, has, d, w));
                exp_v = {(k < TRIG_CYC) || (k == nxt),
                         (k >= glo) && (k <= ghi),
                         isdone && (k == evt),
                         !isdone && (k == evt),
                         (k < nxt - 1) || (k == nxt),
                         (k >= evt) ? enew : perr};
                check($sformatf("rand_ep%0d_k%0d", ep, k), 32'(outs()), 32'(exp_v));
            end
            perr = enew;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
